axi_stream_wr_master: RTL and testbench



---
 rtl/axi_stream_wr_master_if.sv | 71 +++++++
 rtl/axi_stream_wr_master.sv | 147 ++++++++++++++
 tb/tb_axi_stream_wr_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_wr_master_if.sv
// Bundle of command, stream and AXI4 write channels for the stream-to-AXI
// write master; master is the block's view, slave is the environment's.
interface axi_stream_wr_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 16
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_valid;
    logic                  cmd_ready;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid,
        output cmd_ready,
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
        output m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
        output m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid,
        input  cmd_ready,
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
        input  m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
        input  m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi_stream_wr_master.sv
// Moves an AXI-Stream into an AXI4 slave as INCR bursts that never exceed
// MAX_BURST_LEN beats nor cross a 4 KB page; one burst in flight at a time.
module axi_stream_wr_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_stream_wr_master_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int SIZE = $clog2(STRB_WIDTH);
    localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  rem_after;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [8:0]            beat_cnt;
    logic [8:0]            blen;
    logic [CW-1:0]         cap;
    logic                  error_acc;
    logic                  cmd_hs, aw_hs, w_hs, b_hs, last_beat;
    logic                  cmd_ready_c, awvalid_c, wvalid_c, wlast_c;
    logic                  tready_c, bready_c;
    logic                  unused_bid;

    // cur_addr/remaining only move on the B handshake, so blen is stable
    // from AW entry until the burst's response has been taken.
    always_comb begin
        cap = CW'((13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE);
        if (cap > CW'(MAX_BURST_LEN)) cap = CW'(MAX_BURST_LEN);
        if (CW'(remaining) < cap) cap = CW'(remaining);
        blen = cap[8:0];
    end

    assign cmd_hs    = (state == S_IDLE) && bus.cmd_valid;
    assign aw_hs     = (state == S_AW) && bus.m_axi_awready;
    assign w_hs      = (state == S_W) && bus.s_axis_tvalid && bus.m_axi_wready;
    assign b_hs      = (state == S_B) && bus.m_axi_bvalid;
    assign last_beat = (beat_cnt == blen - 9'd1);
    assign rem_after = remaining - LEN_WIDTH'(blen);
    assign addr_step = ADDR_WIDTH'(blen) << SIZE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (bus.cmd_valid)
                state_nx = (bus.cmd_len == '0) ? S_DONE : S_AW;
            S_AW:   if (aw_hs) state_nx = S_W;
            S_W:    if (w_hs && last_beat) state_nx = S_B;
            S_B:    if (b_hs)
                state_nx = (rem_after == '0) ? S_DONE : S_AW;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            error_acc <= 1'b0;
        end else begin
            if (cmd_hs) begin
                cur_addr  <= bus.cmd_addr & ALIGN;
                remaining <= bus.cmd_len;
                error_acc <= 1'b0;
            end
            if (w_hs) beat_cnt <= last_beat ? 9'd0 : beat_cnt + 9'd1;
            if (b_hs) begin
                error_acc <= error_acc | (bus.m_axi_bresp != 2'b00);
                remaining <= rem_after;
                cur_addr  <= cur_addr + addr_step;
            end
        end
    end

    always_comb begin
        cmd_ready_c = 1'b0;
        awvalid_c   = 1'b0;
        wvalid_c    = 1'b0;
        wlast_c     = 1'b0;
        tready_c    = 1'b0;
        bready_c    = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        error       = 1'b0;
        unique case (state)
            S_IDLE: cmd_ready_c = 1'b1;
            S_AW:   awvalid_c = 1'b1;
            S_W: begin
                wvalid_c = bus.s_axis_tvalid;
                tready_c = bus.m_axi_wready;
                wlast_c  = last_beat;
            end
            S_B:    bready_c = 1'b1;
            S_DONE: begin
                done  = 1'b1;
                error = error_acc;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_c;
    assign bus.s_axis_tready = tready_c;
    assign bus.m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign bus.m_axi_awaddr  = cur_addr;
    assign bus.m_axi_awlen   = 8'(blen - 9'd1);
    assign bus.m_axi_awsize  = 3'(SIZE);
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0011;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_c;
    assign bus.m_axi_wdata   = bus.s_axis_tdata;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wlast   = wlast_c;
    assign bus.m_axi_wvalid  = wvalid_c;
    assign bus.m_axi_bready  = bready_c;
    assign unused_bid        = ^bus.m_axi_bid;
endmodule

// File: tb/tb_axi_stream_wr_master.sv
// Bench for axi_stream_wr_master: cycle-driven slave/stream model and an
// arithmetic burst-layout reference.
module tb_axi_stream_wr_master;
    localparam int DW = 32, AW = 16, IW = 8, LW = 16, MAXB = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, done, error;

    always #5 clk = ~clk;

    axi_stream_wr_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

    axi_stream_wr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .AXI_ID(0), .MAX_BURST_LEN(MAXB), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy), .done(done), .error(error));

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] src_q[$];
    logic [31:0] w_data_q[$];
    logic [31:0] mem [int];
    int aw_addr_q[$], aw_len_q[$];
    int exp_addr[$], exp_len[$], exp_baddr[$];
    logic [1:0] bresp_plan[$];
    int done_count, done_iter, acc_iter, rdy_after;
    bit done_err, timed_out;
    int aw_unstable, w_early, wlast_err, bready_drop;

    // Reference burst layout: split by remaining, MAX and 4 KB page
    function automatic void model(input int addr, input int len);
        int a, r, b, page;
        exp_addr.delete(); exp_len.delete(); exp_baddr.delete();
        a = addr & 'hfffc;
        r = len;
        while (r > 0) begin
            page = (4096 - (a % 4096)) / 4;
            b = r;
            if (b > MAXB) b = MAXB;
            if (b > page) b = page;
            exp_addr.push_back(a);
            exp_len.push_back(b);
            for (int j = 0; j < b; j++) exp_baddr.push_back((a + 4 * j) % 65536);
            a = (a + 4 * b) % 65536;
            r -= b;
        end
    endfunction

    // Zero-wait cycle count from acceptance to done: AW + beats + B per burst
    function automatic int full_rate_cycles();
        int c = 1;
        foreach (exp_len[i]) c += exp_len[i] + 2;
        return c;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0;
        bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00; bus.m_axi_bid = '0;
    endtask

    task automatic run_cmd(input int addr, input int len, input bit bp,
                           input int bdelay, input int abort_beats);
        int open = 0, beat_in = 0, cur_len = 0, cur_base = 0;
        int src_idx = 0, bwait = 0, b_count = 0;
        bit armed = 0, bv = 0, tv = 0, tv_hold = 0, cmd_pend = 1;
        bit aw_wait = 0, br_wait = 0;
        logic [15:0] pa = '0;
        logic [7:0] pl = '0;
        src_q.delete(); w_data_q.delete(); mem.delete();
        aw_addr_q.delete(); aw_len_q.delete();
        for (int i = 0; i < len; i++) src_q.push_back($urandom);
        done_count = 0; done_iter = -1; acc_iter = -1; rdy_after = -1;
        done_err = 0; timed_out = 1;
        aw_unstable = 0; w_early = 0; wlast_err = 0; bready_drop = 0;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            bus.cmd_valid = cmd_pend;
            bus.cmd_addr = 16'(addr);
            bus.cmd_len = 16'(len);
            if (!tv_hold) tv = (src_idx < len) && (!bp || $urandom_range(0, 2) != 0);
            bus.s_axis_tvalid = tv;
            bus.s_axis_tdata = (src_idx < len) ? src_q[src_idx] : '0;
            bus.m_axi_awready = !bp || ($urandom_range(0, 1) == 1);
            bus.m_axi_wready = !bp || ($urandom_range(0, 3) != 0);
            if (armed) begin
                if (bwait == 0) begin bv = 1; armed = 0; end
                else bwait--;
            end
            bus.m_axi_bvalid = bv;
            bus.m_axi_bresp = (b_count < bresp_plan.size()) ? bresp_plan[b_count] : 2'b00;
            #1;
            if (bus.cmd_valid && bus.cmd_ready) begin cmd_pend = 0; acc_iter = it; end
            if (aw_wait && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== pa ||
                            bus.m_axi_awlen !== pl)) aw_unstable++;
            aw_wait = bus.m_axi_awvalid && !bus.m_axi_awready;
            pa = bus.m_axi_awaddr;
            pl = bus.m_axi_awlen;
            if (br_wait && !bus.m_axi_bready) bready_drop++;
            br_wait = bus.m_axi_bready && !bus.m_axi_bvalid;
            if ((bus.m_axi_wvalid || bus.s_axis_tready) && open == 0) w_early++;
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                aw_addr_q.push_back(int'(bus.m_axi_awaddr));
                aw_len_q.push_back(int'(bus.m_axi_awlen));
                open++; beat_in = 0;
                cur_len = int'(bus.m_axi_awlen);
                cur_base = int'(bus.m_axi_awaddr);
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                if (bus.m_axi_wlast !== (beat_in == cur_len)) wlast_err++;
                mem[(cur_base + 4 * beat_in) % 65536] = bus.m_axi_wdata;
                w_data_q.push_back(bus.m_axi_wdata);
                beat_in++;
                if (bus.m_axi_wlast) begin open--; armed = 1; bwait = bdelay; end
            end
            if (tv && bus.s_axis_tready) src_idx++;
            tv_hold = tv && !bus.s_axis_tready;
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin bv = 0; b_count++; end
            if (done) begin
                done_count++;
                done_err = error;
                if (done_iter < 0) done_iter = it;
            end
            if (done_iter >= 0 && it == done_iter + 1) begin
                rdy_after = int'(bus.cmd_ready);
                timed_out = 0;
                break;
            end
            if (abort_beats > 0 && w_data_q.size() >= abort_beats) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
             bus.s_axis_tready, done, error, busy} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 10000000",
                {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                 bus.s_axis_tready, done, error, busy});
        end
        n_checks++;
        if ({bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awlock,
             bus.m_axi_awcache, bus.m_axi_awprot, bus.m_axi_wstrb}
            !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF}) begin
            n_err++;
            $display("FAIL constants: got %h want %h",
                {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awlock,
                 bus.m_axi_awcache, bus.m_axi_awprot, bus.m_axi_wstrb},
                {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed();
        int t_addr[3] = '{'h0100, 'h0000, 'h0FF0};
        int t_len[3] = '{4, 40, 8};
        bresp_plan.delete();
        for (int k = 0; k < 3; k++) begin
            run_cmd(t_addr[k], t_len[k], 0, 0, 0);
            model(t_addr[k], t_len[k]);
            n_checks++;
            if (timed_out !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_timeout: got %0d want 0", k, timed_out);
            end
            n_checks++;
            if (aw_addr_q.size() !== exp_addr.size()) begin
                n_err++;
                $display("FAIL dir%0d_aw_count: got %0d want %0d", k,
                    aw_addr_q.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < aw_addr_q.size(); i++) begin
                n_checks++;
                if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== exp_len[i] - 1) begin
                    n_err++;
                    $display("FAIL dir%0d_aw%0d: got %h/%0d want %h/%0d", k, i,
                        aw_addr_q[i], aw_len_q[i], exp_addr[i], exp_len[i] - 1);
                end
            end
            for (int i = 0; i < t_len[k]; i++) begin
                n_checks++;
                if (mem[exp_baddr[i]] !== src_q[i]) begin
                    n_err++;
                    $display("FAIL dir%0d_ram%0d: got %h want %h", k, i,
                        mem[exp_baddr[i]], src_q[i]);
                end
            end
            n_checks++;
            if (done_count !== 1 || done_err !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_done: got cnt %0d err %0d want 1/0", k,
                    done_count, done_err);
            end
            n_checks++;
            if (done_iter - acc_iter !== full_rate_cycles()) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d want %0d", k,
                    done_iter - acc_iter, full_rate_cycles());
            end
            n_checks++;
            if (rdy_after !== 1) begin
                n_err++; $display("FAIL dir%0d_ready_after: got %0d want 1", k, rdy_after);
            end
            n_checks++;
            if (wlast_err !== 0 || w_early !== 0) begin
                n_err++;
                $display("FAIL dir%0d_wproto: got wlast %0d early %0d want 0/0", k,
                    wlast_err, w_early);
            end
        end
    endtask

    task automatic test_backpressure();
        int a, l;
        bresp_plan.delete();
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? 'hFFE8 : int'($urandom_range(0, 65535));
            l = (k == 0) ? 30 : int'($urandom_range(1, 50));
            run_cmd(a, l, 1, 5, 0);
            model(a, l);
            n_checks++;
            if (timed_out !== 1'b0 || done_count !== 1 || done_err !== 1'b0) begin
                n_err++;
                $display("FAIL bp%0d_done: got to %0d cnt %0d err %0d want 0/1/0", k,
                    timed_out, done_count, done_err);
            end
            n_checks++;
            if (aw_addr_q !== exp_addr) begin
                n_err++;
                $display("FAIL bp%0d_aw_addrs: got %0d bursts want %0d", k,
                    aw_addr_q.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_len.size() && i < aw_len_q.size(); i++) begin
                n_checks++;
                if (aw_len_q[i] !== exp_len[i] - 1) begin
                    n_err++;
                    $display("FAIL bp%0d_awlen%0d: got %0d want %0d", k, i,
                        aw_len_q[i], exp_len[i] - 1);
                end
            end
            n_checks++;
            if (w_data_q !== src_q) begin
                n_err++;
                $display("FAIL bp%0d_order: got %0d beats want %0d", k,
                    w_data_q.size(), src_q.size());
            end
            for (int i = 0; i < l; i++) begin
                n_checks++;
                if (mem[exp_baddr[i]] !== src_q[i]) begin
                    n_err++;
                    $display("FAIL bp%0d_ram%0d: got %h want %h", k, i,
                        mem[exp_baddr[i]], src_q[i]);
                end
            end
            n_checks++;
            if ({aw_unstable, bready_drop, w_early, wlast_err} !== '0) begin
                n_err++;
                $display("FAIL bp%0d_proto: got aw %0d b %0d early %0d wlast %0d want 0",
                    k, aw_unstable, bready_drop, w_early, wlast_err);
            end
        end
    endtask

    task automatic test_error();
        bresp_plan.delete();
        bresp_plan.push_back(2'b10);
        bresp_plan.push_back(2'b00);
        run_cmd('h0000, 20, 0, 0, 0);
        bresp_plan.delete();
        n_checks++;
        if (aw_addr_q.size() !== 2 || w_data_q.size() !== 20) begin
            n_err++;
            $display("FAIL err_traffic: got %0d aw %0d beats want 2/20",
                aw_addr_q.size(), w_data_q.size());
        end
        n_checks++;
        if (done_count !== 1 || done_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_flag: got cnt %0d err %0d want 1/1", done_count, done_err);
        end
    endtask

    task automatic test_zero_len();
        run_cmd('h0040, 0, 0, 0, 0);
        n_checks++;
        if (aw_addr_q.size() !== 0 || w_data_q.size() !== 0) begin
            n_err++;
            $display("FAIL zero_traffic: got %0d aw %0d beats want 0/0",
                aw_addr_q.size(), w_data_q.size());
        end
        n_checks++;
        if (timed_out !== 1'b0 || done_iter - acc_iter !== 1) begin
            n_err++;
            $display("FAIL zero_latency: got %0d (to %0d) want 1",
                done_iter - acc_iter, timed_out);
        end
        n_checks++;
        if (done_count !== 1 || done_err !== 1'b0 || rdy_after !== 1) begin
            n_err++;
            $display("FAIL zero_done: got cnt %0d err %0d rdy %0d want 1/0/1",
                done_count, done_err, rdy_after);
        end
    endtask

    task automatic test_reset_mid();
        run_cmd('h0200, 10, 0, 0, 3);
        @(negedge clk);
        rst_n = 0;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
             bus.s_axis_tready, done, error, busy} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL midrst_outputs: got %b want 10000000",
                {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                 bus.s_axis_tready, done, error, busy});
        end
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_cmd('h0300, 5, 0, 0, 0);
        model('h0300, 5);
        n_checks++;
        if (aw_addr_q !== exp_addr || aw_len_q.size() !== 1 || done_count !== 1) begin
            n_err++;
            $display("FAIL midrst_rerun: got %0d aw %0d done want 1/1",
                aw_addr_q.size(), done_count);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem[exp_baddr[i]] !== src_q[i]) begin
                n_err++;
                $display("FAIL midrst_ram%0d: got %h want %h", i,
                    mem[exp_baddr[i]], src_q[i]);
            end
        end
        n_checks++;
        if (done_iter - acc_iter !== full_rate_cycles() || wlast_err !== 0) begin
            n_err++;
            $display("FAIL midrst_timing: got %0d wlast %0d want %0d/0",
                done_iter - acc_iter, wlast_err, full_rate_cycles());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_error();
        test_zero_len();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
